scic_program_loader: RTL

- Sits upstream of the accumulator CPU, between a byte-stream source (UART receiver or testbench) and the shared single-port program/data memory.
- Holds the CPU in reset and streams a length-prefixed image into memory from word 0 upward, then releases the CPU.
- While the CPU runs, the loader is a transparent pass-through of the CPU memory port.
- A new start request re-loads the image.

---
 rtl/scic_program_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/scic_program_loader.sv
// scic_program_loader: holds the CPU in reset, streams a length-prefixed image into memory, then releases the CPU
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   start                 : single-cycle load request (ignored while busy)
//   rx_data/valid/ready   : byte stream in; a byte moves on a rising edge with rx_valid && rx_ready
//   cpu_reset             : active-high CPU reset, low only while the loaded image runs
//   cpu_address/we/data_out : CPU memory port, forwarded to memory only while running
//   mem_address/we/data   : shared memory port
//   busy, error, words_loaded : load status
//   Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and an ERROR state.
module scic_program_loader #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              cpu_reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_data_out,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_data,
  output logic              busy,
  output logic              error,
  output logic [15:0]       words_loaded
);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, DATA, COMMIT, END, CHECK, ERROR, RUN} state_t;
`else
  typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, DATA, COMMIT, END, RUN} state_t;
`endif
  state_t state, state_n;
  logic take, accept_n, busy_n, mem_we_q;
  logic [15:0] len;
  logic [1:0] idx;
  logic [23:0] shift;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_data_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif
  always_comb begin
    take = rx_valid && rx_ready;
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LEN_HI : IDLE;
      LEN_HI:  state_n = take ? LEN_LO : LEN_HI;
      LEN_LO:  state_n = !take ? LEN_LO : ({len[15:8], rx_data} == 16'd0) ? END : DATA;
      DATA:    state_n = (take && idx == 2'd3) ? COMMIT : DATA;
      COMMIT:  state_n = (words_loaded + 16'd1 == len) ? END : DATA;
`ifdef LOADER_CHECKSUM_EN
      END:     state_n = CHECK;
      CHECK:   state_n = !take ? CHECK : (rx_data == csum) ? RUN : ERROR;
      ERROR:   state_n = start ? LEN_HI : ERROR;
`else
      END:     state_n = RUN;
`endif
      RUN:     state_n = start ? LEN_HI : RUN;
      default: state_n = IDLE;
    endcase
    accept_n = state_n == LEN_HI || state_n == LEN_LO || state_n == DATA;
    busy_n = state_n != IDLE && state_n != RUN;
`ifdef LOADER_CHECKSUM_EN
    accept_n = accept_n || state_n == CHECK;
    busy_n = busy_n && state_n != ERROR;
`endif
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rx_ready <= 1'b0;
      cpu_reset <= 1'b1;
      busy <= 1'b0;
      words_loaded <= '0;
      len <= '0;
      idx <= '0;
      shift <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum <= '0;
      error <= 1'b0;
`endif
    end else begin
      state <= state_n;
      rx_ready <= accept_n;
      busy <= busy_n;
      cpu_reset <= state_n != RUN;
      mem_we_q <= state_n == COMMIT;
      if (take && state == LEN_HI) len[15:8] <= rx_data;
      if (take && state == LEN_LO) begin
        len[7:0] <= rx_data;
        words_loaded <= '0;
        idx <= '0;
      end
      if (take && state == DATA) begin
        shift <= {shift[15:0], rx_data};
        idx <= idx + 2'd1;
      end
      // COMMIT is only entered on the 4th byte, so rx_data completes the word here
      if (state_n == COMMIT) begin
        mem_addr_q <= ADDR_W'(words_loaded);
        mem_data_q <= WORD_W'({shift, rx_data});
      end
      if (state == COMMIT) words_loaded <= words_loaded + 16'd1;
`ifdef LOADER_CHECKSUM_EN
      if (take) csum <= (state == LEN_HI ? 8'd0 : csum) ^ rx_data;
      error <= state_n == ERROR;
`endif
    end
  end
`ifndef LOADER_CHECKSUM_EN
  assign error = 1'b0;
`endif
  assign mem_address = (state == RUN) ? cpu_address : mem_addr_q;
  assign mem_we = (state == RUN) ? cpu_we : mem_we_q;
  assign mem_data = (state == RUN) ? cpu_data_out : mem_data_q;
endmodule
